// File: rtl/jam_pkg.sv
// Shared widths, state encoding and reset constants for the JAM cost
// accumulate / minimum tracker.
package jam_pkg;

    localparam int COST_W    = 7;
    localparam int SUM_W     = 10;
    localparam int N_TERMS   = 8;
    localparam int CNT_W     = 4;
    localparam int CNT_IDX_W = 3;

    localparam logic [SUM_W-1:0]     MINCOST_INIT = '1;
    localparam logic [CNT_W-1:0]     MATCH_MAX    = '1;
    localparam logic [CNT_IDX_W-1:0] LAST_TERM    = CNT_IDX_W'(N_TERMS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        CMP  = 2'd2
    } state_t;

endpackage

// File: rtl/cal_cost_2.sv
// Sums N_TERMS successive costs per start pulse, then folds the total into a
// running minimum and a count of assignments that reached that minimum.
import jam_pkg::*;

module cal_cost_2 (
    input  logic              CLK,
    input  logic              RST,
    input  logic [COST_W-1:0] Cost,
    input  logic              start,
    output logic [CNT_W-1:0]  MatchCount,
    output logic [SUM_W-1:0]  MinCost,
    output logic              done
);

    state_t                 state, state_nxt;
    logic [SUM_W-1:0]       acc;
    logic [CNT_IDX_W-1:0]   cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == MATCH_MAX) ? c : c + CNT_W'(1);
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACC;
            ACC:     if (cnt == LAST_TERM) state_nxt = CMP;
            CMP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: cnt counts samples already taken, so the first sample lands in IDLE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc        <= '0;
            cnt        <= '0;
            done       <= 1'b0;
            MinCost    <= MINCOST_INIT;
            MatchCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc <= SUM_W'(Cost);
                        cnt <= CNT_IDX_W'(1);
                    end
                end
                ACC: begin
                    acc <= acc + SUM_W'(Cost);
                    cnt <= cnt + CNT_IDX_W'(1);
                end
                CMP: begin
                    done <= 1'b1;
                    if (acc < MinCost) begin
                        MinCost    <= acc;
                        MatchCount <= CNT_W'(1);
                    end else if (acc == MinCost) begin
                        MatchCount <= sat_inc(MatchCount);
                    end
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cal_cost_2.sv
// Directed, table-driven bench for cal_cost_2: evaluations, ties, saturation,
// ignored start pulses and reset in the middle of an evaluation.
import jam_pkg::*;

module tb_cal_cost_2;

    logic              CLK = 1'b0;
    logic              RST;
    logic              start;
    logic [COST_W-1:0] Cost;
    logic [CNT_W-1:0]  MatchCount;
    logic [SUM_W-1:0]  MinCost;
    logic              done;

    int checks   = 0;
    int failures = 0;
    logic prev_done = 1'b0;

    typedef struct {
        int base;
        bit ramp;
        bit extra;
        int emin;
        int ecnt;
    } vec_t;

    vec_t tbl[9];

    cal_cost_2 dut (
        .CLK        (CLK),
        .RST        (RST),
        .Cost       (Cost),
        .start      (start),
        .MatchCount (MatchCount),
        .MinCost    (MinCost),
        .done       (done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // done must never stay high on two consecutive sampling points
    always @(negedge CLK) begin
        if (done === 1'b1) begin
            checks++;
            if (prev_done === 1'b1) begin
                failures++;
                $display("FAIL done_width actual=2+ cycles expected=1 cycle");
            end
        end
        prev_done = done;
    end

    // Called at a negedge; returns at the negedge just after the CMP edge.
    task automatic run_eval(input int base, input bit ramp, input bit extra,
                            input int emin, input int ecnt, input string nm);
        for (int i = 0; i < N_TERMS; i++) begin
            if (i > 0) chk({nm, "_done_acc"}, 32'(done), 32'd0);
            Cost  = COST_W'(ramp ? base + i : base);
            start = (i == 0) || (extra && (i == 3 || i == 5));
            @(negedge CLK);
        end
        chk({nm, "_done_pre"}, 32'(done), 32'd0);
        start = extra;
        Cost  = '0;
        @(negedge CLK);
        start = 1'b0;
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_min"}, 32'(MinCost), emin);
        chk({nm, "_cnt"}, 32'(MatchCount), ecnt);
    endtask

    initial begin
        tbl[0] = '{50, 1'b0, 1'b0, 400, 1};
        tbl[1] = '{45, 1'b0, 1'b0, 360, 1};
        tbl[2] = '{40, 1'b0, 1'b0, 320, 1};
        tbl[3] = '{35, 1'b0, 1'b0, 280, 1};
        tbl[4] = '{30, 1'b0, 1'b0, 240, 1};
        tbl[5] = '{50, 1'b0, 1'b0, 240, 1};
        tbl[6] = '{30, 1'b0, 1'b0, 240, 2};
        tbl[7] = '{30, 1'b0, 1'b0, 240, 3};
        tbl[8] = '{1,  1'b1, 1'b1, 36,  1};

        RST   = 1'b1;
        start = 1'b0;
        Cost  = '0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        chk("rst_min", 32'(MinCost), 32'd1023);
        chk("rst_cnt", 32'(MatchCount), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        RST = 1'b0;

        for (int k = 0; k < 5; k++) begin
            Cost = COST_W'(k + 3);
            @(negedge CLK);
            chk("idle_min", 32'(MinCost), 32'd1023);
            chk("idle_cnt", 32'(MatchCount), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
        end

        for (int v = 0; v < 9; v++)
            run_eval(tbl[v].base, tbl[v].ramp, tbl[v].extra, tbl[v].emin, tbl[v].ecnt,
                     $sformatf("vec%0d", v));

        // new minimum then 16 ties: count saturates at 15
        run_eval(4, 1'b0, 1'b0, 32, 1, "newmin");
        for (int k = 1; k <= 16; k++)
            run_eval(4, 1'b0, 1'b0, 32, (k + 1 > 15) ? 15 : k + 1, $sformatf("tie%0d", k));
        run_eval(127, 1'b0, 1'b0, 32, 15, "big_nochg");

        // reset asserted ahead of the T4 edge aborts the evaluation
        @(negedge CLK);
        Cost  = COST_W'(10);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("midrst_min", 32'(MinCost), 32'd1023);
        chk("midrst_cnt", 32'(MatchCount), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        for (int k = 0; k < 6; k++) begin
            if (k == 1) RST = 1'b0;
            @(negedge CLK);
            chk("midrst_nodone", 32'(done), 32'd0);
            chk("midrst_min_hold", 32'(MinCost), 32'd1023);
        end

        run_eval(127, 1'b0, 1'b0, 1016, 1, "max_total");
        run_eval(1, 1'b1, 1'b0, 36, 1, "ramp_after_rst");

        @(negedge CLK);
        chk("final_done", 32'(done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
